// File: rtl/udp_pic_rx_parser_if.sv
// UDP RX byte stream in, picture byte stream and status pulses out.
// The master modport drives the UDP side (MAC/bench); the slave modport is the parser.
interface udp_pic_rx_parser_if;
  logic [7:0]  udp_rx_data;
  logic        udp_rx_valid;
  logic        udp_rx_last;
  logic [7:0]  pic_data_o;
  logic        pic_en_o;
  logic [11:0] pic_line_o;
  logic        pic_sof_o;
  logic        line_done_o;
  logic        hdr_err_o;
  logic        len_err_o;

  modport master (
    output udp_rx_data, udp_rx_valid, udp_rx_last,
    input  pic_data_o, pic_en_o, pic_line_o, pic_sof_o,
           line_done_o, hdr_err_o, len_err_o
  );

  modport slave (
    input  udp_rx_data, udp_rx_valid, udp_rx_last,
    output pic_data_o, pic_en_o, pic_line_o, pic_sof_o,
           line_done_o, hdr_err_o, len_err_o
  );
endinterface

// File: rtl/udp_pic_rx_parser.sv
// Image packet parser on the MAC RX clock: validates an 8-byte app header
// (magic, frame id, flags, line, length; big-endian) and forwards only the
// declared payload bytes one cycle late. Malformed packets are dropped whole.
// Optional: define PIC_RX_STATS_EN to add saturating good/bad packet counters.
module udp_pic_rx_parser #(
  parameter logic [15:0] MAGIC          = 16'hA55A,
  parameter int unsigned MAX_LINE_BYTES = 3840,
  parameter int unsigned MAX_LINES      = 1080
) (
  input  logic                mac_rx_clk,
  input  logic                rst_n,
  udp_pic_rx_parser_if.slave  bus
`ifdef PIC_RX_STATS_EN
  ,
  output logic [31:0]         pkt_ok_cnt,
  output logic [31:0]         pkt_err_cnt
`endif
);

  localparam logic [15:0] MAX_LEN_W  = 16'(MAX_LINE_BYTES);
  localparam logic [15:0] MAX_LINE_W = 16'(MAX_LINES);

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAY, ST_DROP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  hdr_cnt_q, hdr_cnt_d;
  logic [7:0]  magic_hi_q, magic_hi_d;
  logic [7:0]  flags_q, flags_d;
  logic [7:0]  line_hi_q, line_hi_d;
  logic [7:0]  line_lo_q, line_lo_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [15:0] remaining_q, remaining_d;
  logic        drop_len_q, drop_len_d;
  logic [7:0]  pic_data_q, pic_data_d;
  logic        pic_en_q, pic_en_d;
  logic [11:0] pic_line_q, pic_line_d;
  logic        pic_sof_q, pic_sof_d;
  logic        line_done_q, line_done_d;
  logic        hdr_err_q, hdr_err_d;
  logic        len_err_q, len_err_d;

  logic [7:0]  din;
  logic        last;
  logic [15:0] hdr_len;
  logic [15:0] hdr_line;
  logic        hdr_bad;

  assign din      = bus.udp_rx_data;
  assign last     = bus.udp_rx_last;
  assign hdr_len  = {len_hi_q, din};
  assign hdr_line = {line_hi_q, line_lo_q};
  assign hdr_bad  = (hdr_len == '0) || (hdr_len > MAX_LEN_W) || (hdr_line >= MAX_LINE_W);

  // Next-state, header capture and output pulse decode; only valid bytes advance anything.
  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    magic_hi_d  = magic_hi_q;
    flags_d     = flags_q;
    line_hi_d   = line_hi_q;
    line_lo_d   = line_lo_q;
    len_hi_d    = len_hi_q;
    remaining_d = remaining_q;
    drop_len_d  = drop_len_q;
    pic_data_d  = pic_data_q;
    pic_line_d  = pic_line_q;
    pic_en_d    = 1'b0;
    pic_sof_d   = 1'b0;
    line_done_d = 1'b0;
    hdr_err_d   = 1'b0;
    len_err_d   = 1'b0;

    if (bus.udp_rx_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          magic_hi_d = din;
          if (last) begin
            hdr_err_d = 1'b1;
          end else begin
            state_d   = ST_HDR;
            hdr_cnt_d = 3'd1;
          end
        end
        ST_HDR: begin
          hdr_cnt_d = hdr_cnt_q + 3'd1;
          case (hdr_cnt_q)
            3'd3:    flags_d   = din;
            3'd4:    line_hi_d = din;
            3'd5:    line_lo_d = din;
            3'd6:    len_hi_d  = din;
            default: ;
          endcase
          // Magic is judged as soon as byte 1 arrives; rest of packet is then discarded.
          if (hdr_cnt_q == 3'd1 && {magic_hi_q, din} != MAGIC) begin
            hdr_err_d  = 1'b1;
            drop_len_d = 1'b0;
            state_d    = last ? ST_IDLE : ST_DROP;
          end else if (last) begin
            hdr_err_d = 1'b1;
            state_d   = ST_IDLE;
          end else if (hdr_cnt_q == 3'd7) begin
            if (hdr_bad) begin
              hdr_err_d  = 1'b1;
              drop_len_d = 1'b0;
              state_d    = ST_DROP;
            end else begin
              state_d     = ST_PAY;
              remaining_d = hdr_len;
              pic_line_d  = hdr_line[11:0];
              pic_sof_d   = flags_q[0];
            end
          end
        end
        ST_PAY: begin
          pic_en_d    = 1'b1;
          pic_data_d  = din;
          remaining_d = remaining_q - 16'd1;
          if (last) begin
            state_d = ST_IDLE;
            if (remaining_q == 16'd1) line_done_d = 1'b1;
            else                      len_err_d   = 1'b1;
          end else if (remaining_q == 16'd1) begin
            // Overlong packet: remember to flag the length error when last finally shows up.
            state_d    = ST_DROP;
            drop_len_d = 1'b1;
          end
        end
        ST_DROP: begin
          if (last) begin
            state_d    = ST_IDLE;
            len_err_d  = drop_len_q;
            drop_len_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge mac_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hdr_cnt_q   <= '0;
      magic_hi_q  <= '0;
      flags_q     <= '0;
      line_hi_q   <= '0;
      line_lo_q   <= '0;
      len_hi_q    <= '0;
      remaining_q <= '0;
      drop_len_q  <= 1'b0;
      pic_data_q  <= '0;
      pic_en_q    <= 1'b0;
      pic_line_q  <= '0;
      pic_sof_q   <= 1'b0;
      line_done_q <= 1'b0;
      hdr_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      magic_hi_q  <= magic_hi_d;
      flags_q     <= flags_d;
      line_hi_q   <= line_hi_d;
      line_lo_q   <= line_lo_d;
      len_hi_q    <= len_hi_d;
      remaining_q <= remaining_d;
      drop_len_q  <= drop_len_d;
      pic_data_q  <= pic_data_d;
      pic_en_q    <= pic_en_d;
      pic_line_q  <= pic_line_d;
      pic_sof_q   <= pic_sof_d;
      line_done_q <= line_done_d;
      hdr_err_q   <= hdr_err_d;
      len_err_q   <= len_err_d;
    end
  end

  assign bus.pic_data_o  = pic_data_q;
  assign bus.pic_en_o    = pic_en_q;
  assign bus.pic_line_o  = pic_line_q;
  assign bus.pic_sof_o   = pic_sof_q;
  assign bus.line_done_o = line_done_q;
  assign bus.hdr_err_o   = hdr_err_q;
  assign bus.len_err_o   = len_err_q;

`ifdef PIC_RX_STATS_EN
  logic [31:0] ok_cnt_q, ok_cnt_d;
  logic [31:0] err_cnt_q, err_cnt_d;

  // Saturating counters advance together with the pulses they count.
  always_comb begin
    ok_cnt_d  = ok_cnt_q;
    err_cnt_d = err_cnt_q;
    if (line_done_d && ok_cnt_q != '1)                 ok_cnt_d  = ok_cnt_q + 32'd1;
    if ((hdr_err_d || len_err_d) && err_cnt_q != '1)   err_cnt_d = err_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge mac_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      ok_cnt_q  <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign pkt_ok_cnt  = ok_cnt_q;
  assign pkt_err_cnt = err_cnt_q;
`endif

endmodule
